// File: rtl/mem_responder.sv
// Word-addressed synchronous memory that answers the MAR/MDR port: accepts Read or
// Write against a captured address, inserts WAIT_STATES wait cycles, and pulses Done.
module mem_responder #(
    parameter int ADDR_W      = 9,
    parameter int DEPTH       = 512,
    parameter int WAIT_STATES = 2
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] address,
    input  logic [31:0] datain,
    input  logic        Read,
    input  logic        Write,
    output logic [31:0] Mdatain,
    output logic        Done,
    output logic        busy,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        DONE    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_LIM = DEPTH[ADDR_W:0];
    localparam logic [3:0]      WCNT_INIT = 4'(WAIT_STATES);

    state_t      state_q;
    logic [3:0]  wcnt_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        dir_wr_q;
    logic [31:0] mdatain_q;
    logic        done_q;
    logic        busy_q;
    logic        addr_err_q;

    logic [31:0] mem [DEPTH];

    logic              req_held;
    logic              in_range;
    logic [ADDR_W-1:0] idx;
    logic              mem_we;

    // The request that matters during ACCESS is the one that was captured, not the live pair.
    assign req_held = dir_wr_q ? Write : Read;
    assign idx      = addr_q[ADDR_W-1:0];
    assign in_range = (addr_q[31:ADDR_W] == '0) && ({1'b0, idx} < DEPTH_LIM);
    assign mem_we   = (state_q == ACCESS) && req_held && (wcnt_q == 4'd0)
                      && dir_wr_q && in_range;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q    <= IDLE;
            wcnt_q     <= 4'd0;
            addr_q     <= '0;
            data_q     <= '0;
            dir_wr_q   <= 1'b0;
            mdatain_q  <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low each edge so they can never stretch past one cycle.
            done_q     <= 1'b0;
            addr_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Read ^ Write) begin
                        addr_q   <= address;
                        data_q   <= datain;
                        dir_wr_q <= Write;
                        wcnt_q   <= WCNT_INIT;
                        state_q  <= ACCESS;
                        busy_q   <= 1'b1;
                    end else if (Read && Write) begin
                        state_q    <= DONE;
                        done_q     <= 1'b1;
                        addr_err_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (!req_held) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (wcnt_q != 4'd0) begin
                        wcnt_q <= wcnt_q - 4'd1;
                    end else begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        if (!in_range) begin
                            addr_err_q <= 1'b1;
                        end else if (!dir_wr_q) begin
                            mdatain_q <= mem[idx];
                        end
                    end
                end
                DONE: begin
                    state_q <= RELEASE;
                end
                RELEASE: begin
                    if (!Read && !Write) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; only the control path is.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[idx] <= data_q;
        end
    end

    assign Mdatain  = mdatain_q;
    assign Done     = done_q;
    assign busy     = busy_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances with WAIT_STATES 2, 0 and 5.
module tb_mem_responder;

    localparam int WS_T [3] = '{2, 0, 5};

    logic        clk;
    logic [2:0]  clear_v;
    logic [2:0]  rd_v;
    logic [2:0]  wr_v;
    logic [31:0] addr_v [3];
    logic [31:0] din_v  [3];
    wire  [31:0] mdata_v [3];
    wire  [2:0]  done_v;
    wire  [2:0]  busy_v;
    wire  [2:0]  aerr_v;

    int n_pass;
    int n_total;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_responder #(
            .ADDR_W     (9),
            .DEPTH      (512),
            .WAIT_STATES(WS_T[g])
        ) u_dut (
            .clock   (clk),
            .clear   (clear_v[g]),
            .address (addr_v[g]),
            .datain  (din_v[g]),
            .Read    (rd_v[g]),
            .Write   (wr_v[g]),
            .Mdatain (mdata_v[g]),
            .Done    (done_v[g]),
            .busy    (busy_v[g]),
            .addr_err(aerr_v[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request, scramble address/data after acceptance, and report when Done is seen.
    // lat is the number of posedges from acceptance to the edge that samples Done high.
    task automatic do_req(input int u, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d, input int hold,
                          output int lat, output logic err, output logic [31:0] rdata,
                          output logic done_after, output int extra);
        int edges;
        lat = -1; err = 1'bx; rdata = 'x; done_after = 1'bx; extra = 0;
        @(negedge clk);
        rd_v[u] = r; wr_v[u] = w; addr_v[u] = a; din_v[u] = d;
        @(posedge clk);
        edges = 0;
        while (edges < 40) begin
            @(negedge clk);
            if (edges == 0) begin
                addr_v[u] = ~a;
                din_v[u]  = ~d;
            end
            if (done_v[u]) begin
                lat   = edges + 1;
                err   = aerr_v[u];
                rdata = mdata_v[u];
                break;
            end
            @(posedge clk);
            edges++;
        end
        if (hold == 0) begin
            rd_v[u] = 1'b0; wr_v[u] = 1'b0;
        end
        @(negedge clk);
        done_after = done_v[u];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (done_v[u]) extra++;
        end
        rd_v[u] = 1'b0; wr_v[u] = 1'b0;
        for (int i = 0; i < 10 && busy_v[u]; i++) @(negedge clk);
        if (busy_v[u]) lat = -2;
    endtask

    task automatic test_reset();
        n_total++; if (mdata_v[0] !== 32'h0) $display("FAIL rst_mdatain: got %h expected %h", mdata_v[0], 32'h0); else n_pass++;
        n_total++; if (done_v[0] !== 1'b0) $display("FAIL rst_done: got %b expected 0", done_v[0]); else n_pass++;
        n_total++; if (busy_v[0] !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy_v[0]); else n_pass++;
        n_total++; if (aerr_v[0] !== 1'b0) $display("FAIL rst_addr_err: got %b expected 0", aerr_v[0]); else n_pass++;
        @(negedge clk);
        clear_v = 3'b000;
    endtask

    task automatic test_write_read();
        int lat, extra; logic err, da; logic [31:0] rdata;
        do_req(0, 1'b0, 1'b1, 32'h55, 32'h0000BEEF, 0, lat, err, rdata, da, extra);
        n_total++; if (lat !== 4) $display("FAIL wr55_latency: got %0d expected 4", lat); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL wr55_addr_err: got %b expected 0", err); else n_pass++;
        n_total++; if (da !== 1'b0) $display("FAIL wr55_done_width: got %b expected 0", da); else n_pass++;
        do_req(0, 1'b1, 1'b0, 32'h55, 32'h0, 0, lat, err, rdata, da, extra);
        n_total++; if (lat !== 4) $display("FAIL rd55_latency: got %0d expected 4", lat); else n_pass++;
        n_total++; if (rdata !== 32'h0000BEEF) $display("FAIL rd55_data: got %h expected %h", rdata, 32'h0000BEEF); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL rd55_addr_err: got %b expected 0", err); else n_pass++;
    endtask

    task automatic test_latency();
        int lat, extra; logic err, da; logic [31:0] rdata;
        for (int u = 1; u < 3; u++) begin
            do_req(u, 1'b0, 1'b1, 32'h3, 32'h1000 + u, 0, lat, err, rdata, da, extra);
            n_total++; if (lat !== WS_T[u] + 2) $display("FAIL lat_wr_u%0d: got %0d expected %0d", u, lat, WS_T[u] + 2); else n_pass++;
            do_req(u, 1'b1, 1'b0, 32'h3, 32'h0, 6, lat, err, rdata, da, extra);
            n_total++; if (lat !== WS_T[u] + 2) $display("FAIL lat_rd_u%0d: got %0d expected %0d", u, lat, WS_T[u] + 2); else n_pass++;
            n_total++; if (rdata !== 32'h1000 + u) $display("FAIL lat_data_u%0d: got %h expected %h", u, rdata, 32'h1000 + u); else n_pass++;
            n_total++; if (da !== 1'b0) $display("FAIL lat_done_width_u%0d: got %b expected 0", u, da); else n_pass++;
            n_total++; if (extra !== 0) $display("FAIL lat_held_redone_u%0d: got %0d expected 0", u, extra); else n_pass++;
        end
    endtask

    task automatic test_abort();
        int lat, extra, dones; logic err, da; logic [31:0] rdata;
        do_req(0, 1'b0, 1'b1, 32'h10, 32'h0000AAAA, 0, lat, err, rdata, da, extra);
        n_total++; if (lat !== 4) $display("FAIL abort_setup_latency: got %0d expected 4", lat); else n_pass++;
        @(negedge clk);
        wr_v[0] = 1'b1; addr_v[0] = 32'h10; din_v[0] = 32'h0000DEAD;
        @(posedge clk);
        @(negedge clk);
        n_total++; if (busy_v[0] !== 1'b1) $display("FAIL abort_in_access: got %b expected 1", busy_v[0]); else n_pass++;
        wr_v[0] = 1'b0;
        dones = 0;
        @(negedge clk);
        n_total++; if (busy_v[0] !== 1'b0) $display("FAIL abort_to_idle: got %b expected 0", busy_v[0]); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            if (done_v[0]) dones++;
            @(negedge clk);
        end
        n_total++; if (dones !== 0) $display("FAIL abort_no_done: got %0d expected 0", dones); else n_pass++;
        do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 0, lat, err, rdata, da, extra);
        n_total++; if (rdata !== 32'h0000AAAA) $display("FAIL abort_readback: got %h expected %h", rdata, 32'h0000AAAA); else n_pass++;
    endtask

    task automatic test_illegal();
        int lat, extra; logic err, da; logic [31:0] rdata;
        do_req(0, 1'b1, 1'b1, 32'h10, 32'h00005555, 0, lat, err, rdata, da, extra);
        n_total++; if (lat !== 1) $display("FAIL illegal_latency: got %0d expected 1", lat); else n_pass++;
        n_total++; if (err !== 1'b1) $display("FAIL illegal_addr_err: got %b expected 1", err); else n_pass++;
        n_total++; if (rdata !== 32'h0000AAAA) $display("FAIL illegal_mdatain_hold: got %h expected %h", rdata, 32'h0000AAAA); else n_pass++;
        do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 0, lat, err, rdata, da, extra);
        n_total++; if (rdata !== 32'h0000AAAA) $display("FAIL illegal_mem_unchanged: got %h expected %h", rdata, 32'h0000AAAA); else n_pass++;
    endtask

    task automatic test_bounds();
        int lat, extra; logic err, da; logic [31:0] rdata;
        do_req(0, 1'b1, 1'b0, 32'h200, 32'h0, 0, lat, err, rdata, da, extra);
        n_total++; if (lat !== 4) $display("FAIL oob200_latency: got %0d expected 4", lat); else n_pass++;
        n_total++; if (err !== 1'b1) $display("FAIL oob200_addr_err: got %b expected 1", err); else n_pass++;
        n_total++; if (rdata !== 32'h0000AAAA) $display("FAIL oob200_mdatain_hold: got %h expected %h", rdata, 32'h0000AAAA); else n_pass++;
        do_req(0, 1'b0, 1'b1, 32'h1FF, 32'hCAFEF00D, 0, lat, err, rdata, da, extra);
        n_total++; if (err !== 1'b0) $display("FAIL wr1ff_addr_err: got %b expected 0", err); else n_pass++;
        do_req(0, 1'b1, 1'b0, 32'h1FF, 32'h0, 0, lat, err, rdata, da, extra);
        n_total++; if (rdata !== 32'hCAFEF00D) $display("FAIL rd1ff_data: got %h expected %h", rdata, 32'hCAFEF00D); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL rd1ff_addr_err: got %b expected 0", err); else n_pass++;
        do_req(0, 1'b1, 1'b0, 32'h80000001, 32'h0, 0, lat, err, rdata, da, extra);
        n_total++; if (err !== 1'b1) $display("FAIL oob_high_addr_err: got %b expected 1", err); else n_pass++;
        n_total++; if (rdata !== 32'hCAFEF00D) $display("FAIL oob_high_mdatain_hold: got %h expected %h", rdata, 32'hCAFEF00D); else n_pass++;
    endtask

    task automatic test_reset_mid_write();
        int lat, extra; logic err, da; logic [31:0] rdata;
        do_req(0, 1'b0, 1'b1, 32'h20, 32'h00001111, 0, lat, err, rdata, da, extra);
        n_total++; if (lat !== 4) $display("FAIL rmw_setup_latency: got %0d expected 4", lat); else n_pass++;
        @(negedge clk);
        wr_v[0] = 1'b1; addr_v[0] = 32'h20; din_v[0] = 32'h00001234;
        @(posedge clk);
        @(negedge clk);
        #2 clear_v[0] = 1'b1;
        #1;
        n_total++; if (busy_v[0] !== 1'b0) $display("FAIL rmw_idle: got %b expected 0", busy_v[0]); else n_pass++;
        wr_v[0] = 1'b0;
        @(negedge clk);
        clear_v[0] = 1'b0;
        do_req(0, 1'b1, 1'b0, 32'h20, 32'h0, 0, lat, err, rdata, da, extra);
        n_total++; if (rdata !== 32'h00001111) $display("FAIL rmw_old_value: got %h expected %h", rdata, 32'h00001111); else n_pass++;
    endtask

    task automatic test_reset_async();
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        rd_v[0] = 1'b1; addr_v[0] = 32'h55;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done_v[0]) seen = 1'b1;
        end
        n_total++; if (seen !== 1'b1) $display("FAIL async_done_seen: got %b expected 1", seen); else n_pass++;
        n_total++; if (mdata_v[0] !== 32'h0000BEEF) $display("FAIL async_pre_data: got %h expected %h", mdata_v[0], 32'h0000BEEF); else n_pass++;
        #2 clear_v[0] = 1'b1;
        #1;
        n_total++; if (mdata_v[0] !== 32'h0) $display("FAIL async_mdatain: got %h expected %h", mdata_v[0], 32'h0); else n_pass++;
        n_total++; if (done_v[0] !== 1'b0) $display("FAIL async_done: got %b expected 0", done_v[0]); else n_pass++;
        n_total++; if (busy_v[0] !== 1'b0) $display("FAIL async_busy: got %b expected 0", busy_v[0]); else n_pass++;
        rd_v[0] = 1'b0;
        @(negedge clk);
        clear_v[0] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        clear_v = 3'b111;
        rd_v    = 3'b000;
        wr_v    = 3'b000;
        for (int i = 0; i < 3; i++) begin
            addr_v[i] = 32'h0;
            din_v[i]  = 32'h0;
        end
        repeat (2) @(negedge clk);
        test_reset();
        test_write_read();
        test_latency();
        test_abort();
        test_illegal();
        test_bounds();
        test_reset_mid_write();
        test_reset_async();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
